// File: rtl/instability_pkg.sv
// Shared types for the instability sweep controller and its drop comparator.
package instability_pkg;

    localparam int unsigned WIDTH_DEF = 10;
    localparam int unsigned IREF_MAX  = (1 << WIDTH_DEF) - 1;

    typedef logic [WIDTH_DEF-1:0] iref_t;
    typedef logic [WIDTH_DEF-1:0] q_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/instability_drop_cmp.sv
// Flags a Q drop strictly larger than DELTA between two consecutive samples.
module instability_drop_cmp #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DELTA = 50
) (
    input  logic [WIDTH-1:0] i_last_q,
    input  logic [WIDTH-1:0] i_q_cur,
    output logic             o_drop_found
);

    localparam logic [WIDTH:0] L_DELTA = (WIDTH+1)'(DELTA);

    logic [WIDTH-1:0] w_diff;

    assign w_diff       = i_last_q - i_q_cur;
    assign o_drop_found = (i_last_q > i_q_cur) && ({1'b0, w_diff} > L_DELTA);

endmodule

// File: rtl/instability_sweep_ctrl.sv
// Sweeps i_ref upward, measures Q per step and reports a backed-off current at the first large Q drop.
// Optional build macro INSTAB_AVG_EN: four transfers per step, averaged into q_cur.
module instability_sweep_ctrl
    import instability_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned DELTA        = 50,
    parameter int unsigned IREF_START   = 0,
    parameter int unsigned IREF_STEP    = 10,
    parameter int unsigned IREF_BACKOFF = 10,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             meas_req,
    input  logic             meas_valid,
    input  logic [WIDTH-1:0] q_meas,
    output logic [WIDTH-1:0] i_ref,
    output logic [WIDTH-1:0] i_ref_setup,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [WIDTH-1:0] L_START    = WIDTH'(IREF_START);
    localparam logic [WIDTH-1:0] L_BACKOFF  = WIDTH'(IREF_BACKOFF);
    localparam logic [WIDTH:0]   L_STEP     = (WIDTH+1)'(IREF_STEP);
    localparam logic [WIDTH:0]   L_IREF_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [SET_W-1:0] L_SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] L_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    function automatic logic [WIDTH-1:0] f_sat_sub(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_iref, r_setup, r_last_q, r_q_cur;
    logic             r_first;
    logic [SET_W-1:0] r_set_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic             w_xfer, w_tmo, w_drop, w_step_ovf, w_start_ok, w_meas_last;
    logic [WIDTH:0]   w_iref_sum;

`ifdef INSTAB_AVG_EN
    logic [WIDTH+1:0] r_acc;
    logic [1:0]       r_xfer_cnt;
    logic [WIDTH+1:0] w_acc_sum;

    assign w_acc_sum   = r_acc + {2'b00, q_meas};
    assign w_meas_last = (r_xfer_cnt == 2'd3);
`else
    assign w_meas_last = 1'b1;
`endif

    // meas_req is a decode of the registered state, so a transfer is only possible in MEASURE
    assign w_xfer     = (r_state == S_MEASURE) && meas_valid;
    assign w_tmo      = (r_state == S_MEASURE) && !meas_valid && (r_tmo_cnt == L_TMO_LAST);
    assign w_iref_sum = {1'b0, r_iref} + L_STEP;
    assign w_step_ovf = (w_iref_sum > L_IREF_MAX);
    assign w_start_ok = start && !abort;

    instability_drop_cmp #(
        .WIDTH (WIDTH),
        .DELTA (DELTA)
    ) u_drop_cmp (
        .i_last_q     (r_last_q),
        .i_q_cur      (r_q_cur),
        .o_drop_found (w_drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: if (w_start_ok) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (abort)                  w_state_nxt = S_IDLE;
                else if (r_set_cnt == '0)   w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (abort)                      w_state_nxt = S_IDLE;
                else if (w_xfer && w_meas_last) w_state_nxt = S_EVAL;
                else if (w_tmo)                 w_state_nxt = S_FAIL;
            end
            S_EVAL: begin
                if (abort)                  w_state_nxt = S_IDLE;
                else if (!r_first && w_drop) w_state_nxt = S_DONE;
                else if (w_step_ovf)        w_state_nxt = S_FAIL;
                else                        w_state_nxt = S_SETTLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_EVAL);
        meas_req    = (r_state == S_MEASURE);
        done        = (r_state == S_DONE);
        fail        = (r_state == S_FAIL);
        i_ref       = r_iref;
        i_ref_setup = r_setup;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iref    <= L_START;
            r_setup   <= '0;
            r_last_q  <= '0;
            r_q_cur   <= '0;
            r_first   <= 1'b1;
            r_set_cnt <= '0;
            r_tmo_cnt <= '0;
`ifdef INSTAB_AVG_EN
            r_acc      <= '0;
            r_xfer_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_start_ok) begin
                        r_iref    <= L_START;
                        r_first   <= 1'b1;
                        r_set_cnt <= L_SET_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_iref <= L_START;
                    end else begin
                        r_set_cnt <= r_set_cnt - SET_W'(1);
                        r_tmo_cnt <= '0;
`ifdef INSTAB_AVG_EN
                        r_acc      <= '0;
                        r_xfer_cnt <= '0;
`endif
                    end
                end
                S_MEASURE: begin
                    if (abort) begin
                        r_iref <= L_START;
                    end else if (w_xfer) begin
`ifdef INSTAB_AVG_EN
                        if (w_meas_last) begin
                            r_q_cur <= w_acc_sum[WIDTH+1:2];
                        end else begin
                            r_acc      <= w_acc_sum;
                            r_xfer_cnt <= r_xfer_cnt + 2'd1;
                            r_tmo_cnt  <= '0;
                        end
`else
                        r_q_cur <= q_meas;
`endif
                    end else if (w_tmo) begin
                        r_setup <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_EVAL: begin
                    if (abort) begin
                        r_iref <= L_START;
                    end else begin
                        // The first sample of a sweep only primes last_q
                        if (r_first) r_first <= 1'b0;
                        if (!r_first && w_drop) begin
                            r_setup <= f_sat_sub(r_iref, L_BACKOFF);
                        end else if (w_step_ovf) begin
                            r_setup <= '0;
                        end else begin
                            r_iref    <= w_iref_sum[WIDTH-1:0];
                            r_last_q  <= r_q_cur;
                            r_set_cnt <= L_SET_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instability_sweep_ctrl.sv
// Scoreboard bench: stimulus pushes expected sweep outcomes, a monitor pops them on done/fail.
module tb_instability_sweep_ctrl;

    localparam int W = 10;

    typedef struct {
        bit done;
        bit fail;
        int iref;
        int setup;
        int nreq;
        int lat;
        int tmo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         meas_valid = 1'b0;
    logic [W-1:0] q_meas = '0;

    int sel = 0;
    int scen = 0;
    bit model_on = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];

    logic         start_a, start_b, start_c;
    logic         req_a, req_b, req_c;
    logic [W-1:0] iref_a, iref_b, iref_c;
    logic [W-1:0] setup_a, setup_b, setup_c;
    logic         busy_a, busy_b, busy_c;
    logic         done_a, done_b, done_c;
    logic         fail_a, fail_b, fail_c;

    logic         m_req, m_busy, m_done, m_fail;
    logic [W-1:0] m_iref, m_setup;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    always #5 clk = ~clk;

    instability_sweep_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .meas_req(req_a), .meas_valid(meas_valid), .q_meas(q_meas),
        .i_ref(iref_a), .i_ref_setup(setup_a),
        .busy(busy_a), .done(done_a), .fail(fail_a)
    );

    instability_sweep_ctrl #(.IREF_START(5)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .meas_req(req_b), .meas_valid(meas_valid), .q_meas(q_meas),
        .i_ref(iref_b), .i_ref_setup(setup_b),
        .busy(busy_b), .done(done_b), .fail(fail_b)
    );

    instability_sweep_ctrl #(.IREF_START(0), .IREF_STEP(5)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort),
        .meas_req(req_c), .meas_valid(meas_valid), .q_meas(q_meas),
        .i_ref(iref_c), .i_ref_setup(setup_c),
        .busy(busy_c), .done(done_c), .fail(fail_c)
    );

    always_comb begin
        m_req = req_a; m_busy = busy_a; m_done = done_a; m_fail = fail_a;
        m_iref = iref_a; m_setup = setup_a;
        case (sel)
            1: begin
                m_req = req_b; m_busy = busy_b; m_done = done_b; m_fail = fail_b;
                m_iref = iref_b; m_setup = setup_b;
            end
            2: begin
                m_req = req_c; m_busy = busy_c; m_done = done_c; m_fail = fail_c;
                m_iref = iref_c; m_setup = setup_c;
            end
            default: ;
        endcase
    end

    function automatic int f_model(input int s, input int i);
        case (s)
            2: return (i == 500) ? 400 : i;
            3: return (i == 500) ? 440 : i;
            4: return (i == 500) ? 439 : i;
            5: return (i < 5) ? 100 : ((i == 5) ? 0 : i);
            6: return (i == 0) ? 100 : ((i == 5) ? 0 : i);
            default: return i;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit d, input bit f, input int ir, input int su,
                        input int nr, input int lt, input int tm);
        exp_t e;
        e.done = d; e.fail = f; e.iref = ir; e.setup = su;
        e.nreq = nr; e.lat = lt; e.tmo = tm;
        sb.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: until idle, 1: until meas_req, 2: until i_ref == val
    task automatic wait_cond(input int mode, input int val, input int budget);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            case (mode)
                0: hit = !m_busy;
                1: hit = m_req;
                default: hit = (int'(m_iref) == val);
            endcase
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_mode%0d: got timeout after %0d cycles, expected event", mode, budget);
        end
    endtask

    // Measurement model: valid one cycle after meas_req, Q = f(i_ref)
    initial begin
        int age;
        age = 0;
        forever begin
            @(negedge clk);
            if (meas_valid) begin
                meas_valid = 1'b0;
                age = 0;
            end else if (m_req && model_on) begin
                if (age == 1) begin
                    meas_valid = 1'b1;
                    q_meas = W'(f_model(scen, int'(m_iref)));
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: pops one expected outcome whenever done or fail rises
    initial begin
        logic p_busy, p_req, p_done, p_fail;
        int n_req, lat, since;
        bit lat_got;
        exp_t e;
        p_busy = 1'b0; p_req = 1'b0; p_done = 1'b0; p_fail = 1'b0;
        n_req = 0; lat = 0; since = 0; lat_got = 1'b0;
        forever begin
            @(negedge clk);
            if (m_busy && !p_busy) begin
                n_req = 0;
                lat = 0;
                lat_got = 1'b0;
            end
            if (m_req && !p_req) begin
                n_req++;
                since = 0;
                lat_got = 1'b1;
            end else begin
                since++;
                if (m_busy && !lat_got) lat++;
            end
            if ((m_done && !p_done) || (m_fail && !p_fail)) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_end: got done=%0d fail=%0d, expected no outcome", m_done, m_fail);
                end else begin
                    e = sb.pop_front();
                    chk("res_done", m_done, e.done);
                    chk("res_fail", m_fail, e.fail);
                    chk("res_busy", m_busy, 0);
                    chk("res_iref", m_iref, e.iref);
                    chk("res_setup", m_setup, e.setup);
                    chk("res_nreq", n_req, e.nreq);
                    chk("res_settle_lat", lat, e.lat);
                    if (e.tmo >= 0) chk("res_timeout_lat", since, e.tmo);
                end
            end
            p_busy = m_busy; p_req = m_req; p_done = m_done; p_fail = m_fail;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_req", req_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_iref", iref_a, 0);
        chk("rst_setup", setup_a, 0);
        chk("rst_iref_start5", iref_b, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        sel = 0;
        model_on = 1'b1;
        scen = 1;
        push(0, 1, 1020, 0, 103, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);

        scen = 2;
        push(1, 0, 500, 490, 51, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);

        scen = 3;
        push(0, 1, 1020, 0, 103, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);

        scen = 4;
        push(1, 0, 500, 490, 51, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);

        scen = 1;
        do_start();
        wait_cond(2, 30, 200);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_req", req_a, 0);
        chk("abort_iref", iref_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_fail", fail_a, 0);
        chk("abort_setup_kept", setup_a, 490);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", busy_a, 0);

        model_on = 1'b0;
        do_start();
        wait_cond(1, 0, 50);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_req", req_a, 0);
        chk("midrst_iref", iref_a, 0);
        chk("midrst_setup", setup_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_fail", fail_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        push(0, 1, 0, 0, 1, 4, 64);
        do_start();
        wait_cond(0, 0, 200);
        @(negedge clk);
        chk("timeout_req_low", req_a, 0);
        model_on = 1'b1;

        sel = 1;
        scen = 1;
        push(0, 1, 1015, 0, 102, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);
        scen = 5;
        push(0, 1, 1015, 0, 102, 4, -1);
        do_start();
        wait_cond(0, 0, 2000);

        sel = 2;
        scen = 6;
        push(1, 0, 5, 0, 2, 4, -1);
        do_start();
        wait_cond(0, 0, 200);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
